// File: rtl/clksw_seq.sv
// clksw_seq: sequences glitch-safe HS/LS clock-switch requests and stalls the CPU until acked.
// Revision: 1.0
`default_nettype none

module clksw_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int DWELL_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       hsclk_in,
  input  logic       rst,
  input  logic       ls_access_req,
  input  logic       hs_access_req,
  input  logic       cfg_we,
  input  logic [2:0] cfg_data,
  input  logic       hsclk_selected_in,
  input  logic       lsclk_selected_in,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       cpu_rdy,
  output logic       switch_err
);

  typedef enum logic [2:0] {
    LS_RUN = 3'd0,
    TO_HS  = 3'd1,
    HS_RUN = 3'd2,
    TO_LS  = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] hs_sync;
  logic [SYNC_STAGES-1:0] ls_sync;
  logic                   hs_s;
  logic                   ls_s;
  logic [2:0]             cfg_q;
  logic [CNT_W-1:0]       dwell;
  logic [CNT_W-1:0]       tmo;
  logic                   go_hs;
  logic [CNT_W-1:0]       tmo_inc;

  // LS flag resets high so the sequencer starts consistent with the LS clock in use.
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      hs_sync <= '0;
      ls_sync <= '1;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], hsclk_selected_in};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], lsclk_selected_in};
    end
  end

  assign hs_s = hs_sync[SYNC_STAGES-1];
  assign ls_s = ls_sync[SYNC_STAGES-1];

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) cfg_q <= 3'b000;
    else if (cfg_we) cfg_q <= cfg_data;
  end

  assign go_hs   = cfg_q[2] & hs_access_req & ~ls_access_req & (dwell == '0);
  assign tmo_inc = (tmo == CNT_MAX) ? tmo : tmo + 1'b1;

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state          <= LS_RUN;
      hsclk_sel      <= 1'b0;
      cpu_rdy        <= 1'b1;
      switch_err     <= 1'b0;
      cpuclk_div_sel <= 2'b00;
      dwell          <= DWELL_LD;
      tmo            <= '0;
    end else begin
      dwell <= (dwell == '0) ? dwell : dwell - 1'b1;
      unique case (state)
        LS_RUN: begin
          if (ls_access_req) dwell <= DWELL_LD;
          if (go_hs) begin
            state     <= TO_HS;
            hsclk_sel <= 1'b1;
            cpu_rdy   <= 1'b0;
            tmo       <= '0;
          end else begin
            // Held on the departing edge so a divider move never lands with hsclk_sel rising.
            cpuclk_div_sel <= cfg_q[1:0];
          end
        end
        TO_HS: begin
          tmo <= tmo_inc;
          if (hs_s && !ls_s) begin
            state   <= HS_RUN;
            cpu_rdy <= 1'b1;
          end else if (tmo == TO_LIM) begin
            state      <= FAULT;
            hsclk_sel  <= 1'b0;
            switch_err <= 1'b1;
            cpu_rdy    <= ls_s;
          end
        end
        HS_RUN: begin
          if (ls_access_req || !cfg_q[2]) begin
            state     <= TO_LS;
            hsclk_sel <= 1'b0;
            cpu_rdy   <= 1'b0;
            tmo       <= '0;
          end
        end
        TO_LS: begin
          tmo <= tmo_inc;
          if (ls_s && !hs_s) begin
            state   <= LS_RUN;
            cpu_rdy <= 1'b1;
            dwell   <= DWELL_LD;
          end else if (tmo == TO_LIM) begin
            state      <= FAULT;
            switch_err <= 1'b1;
            cpu_rdy    <= ls_s;
          end
        end
        FAULT: begin
          cpu_rdy <= ls_s;
          if (cfg_we && !cfg_data[2] && ls_s) begin
            state      <= LS_RUN;
            switch_err <= 1'b0;
            cpu_rdy    <= 1'b1;
            dwell      <= DWELL_LD;
          end
        end
        default: begin
          state     <= LS_RUN;
          hsclk_sel <= 1'b0;
          cpu_rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clksw_seq.sv
// tb_clksw_seq: directed table plus hand sequences for the clock-switch sequencer.
`default_nettype none

module tb_clksw_seq;

  logic       hsclk_in = 1'b0;
  logic       rst = 1'b1;
  logic       ls_access_req = 1'b0;
  logic       hs_access_req = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_data = 3'b000;
  logic       hsclk_selected_in = 1'b0;
  logic       lsclk_selected_in = 1'b1;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       cpu_rdy;
  logic       switch_err;

  int n_chk  = 0;
  int n_fail = 0;

  clksw_seq dut (
    .hsclk_in          (hsclk_in),
    .rst               (rst),
    .ls_access_req     (ls_access_req),
    .hs_access_req     (hs_access_req),
    .cfg_we            (cfg_we),
    .cfg_data          (cfg_data),
    .hsclk_selected_in (hsclk_selected_in),
    .lsclk_selected_in (lsclk_selected_in),
    .hsclk_sel         (hsclk_sel),
    .cpuclk_div_sel    (cpuclk_div_sel),
    .cpu_rdy           (cpu_rdy),
    .switch_err        (switch_err)
  );

  always #5 hsclk_in = ~hsclk_in;

  // Expected outputs packed as {hsclk_sel, cpu_rdy, cpuclk_div_sel[1:0], switch_err}.
  task automatic chk(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {hsclk_sel, cpu_rdy, cpuclk_div_sel, switch_err};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sel/rdy/div/err=%b required %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hsclk_in);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       ls;
    logic       hs;
    logic       we;
    logic [2:0] data;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{"cfg_101_pending",  1'b0, 1'b0, 1'b1, 3'b101, 5'b01000};
    tbl[1] = '{"div_follows_01",   1'b0, 1'b0, 1'b0, 3'b000, 5'b01010};
    tbl[2] = '{"hs_blocked_dwell", 1'b0, 1'b1, 1'b0, 3'b000, 5'b01010};
    tbl[3] = '{"cfg_010_pending",  1'b0, 1'b0, 1'b1, 3'b010, 5'b01010};
    tbl[4] = '{"div_follows_10",   1'b0, 1'b0, 1'b0, 3'b000, 5'b01100};
    tbl[5] = '{"cfg_101_again",    1'b0, 1'b0, 1'b1, 3'b101, 5'b01100};
    tbl[6] = '{"div_back_01",      1'b0, 1'b0, 1'b0, 3'b000, 5'b01010};

    step();
    chk("reset_state", 5'b01000);
    step();
    rst = 1'b0;
    step();
    chk("after_release", 5'b01000);

    for (int i = 0; i < 7; i++) begin
      ls_access_req = tbl[i].ls;
      hs_access_req = tbl[i].hs;
      cfg_we        = tbl[i].we;
      cfg_data      = tbl[i].data;
      step();
      chk(tbl[i].name, tbl[i].exp);
    end
    ls_access_req = 1'b0;
    hs_access_req = 1'b0;
    cfg_we        = 1'b0;

    // HS entry after the dwell has expired
    for (int i = 0; i < 17; i++) step();
    hs_access_req = 1'b1;
    step();
    hs_access_req = 1'b0;
    chk("hs_entry_edge", 5'b10010);
    hsclk_selected_in = 1'b1;
    lsclk_selected_in = 1'b0;
    step();
    chk("hs_stall_1", 5'b10010);
    step();
    chk("hs_stall_2", 5'b10010);
    step();
    chk("hs_release", 5'b11010);

    // Divider write while in HS must not move the divider
    cfg_we   = 1'b1;
    cfg_data = 3'b111;
    step();
    cfg_we = 1'b0;
    chk("hs_div_held_0", 5'b11010);
    for (int i = 0; i < 3; i++) step();
    chk("hs_div_held_3", 5'b11010);

    // LS access from HS
    ls_access_req = 1'b1;
    step();
    ls_access_req = 1'b0;
    chk("ls_switch_edge", 5'b00010);
    for (int i = 0; i < 4; i++) step();
    chk("ls_stall_noack", 5'b00010);
    hsclk_selected_in = 1'b0;
    lsclk_selected_in = 1'b1;
    step();
    step();
    chk("ls_stall_sync", 5'b00010);
    step();
    chk("ls_release_div_old", 5'b01010);
    hs_access_req = 1'b1;
    step();
    chk("ls_first_div_11", 5'b01110);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("dwell_hold_hs", 5'b01110);
    end
    step();
    chk("dwell_expired_switch", 5'b10110);
    hs_access_req = 1'b0;

    // Asynchronous reset mid-TO_HS
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_immediate", 5'b01000);
    step();
    chk("reset_held", 5'b01000);
    rst = 1'b0;
    step();
    chk("reset_released_hold", 5'b01000);

    // Simultaneous requests: LS wins and the dwell reloads
    cfg_we   = 1'b1;
    cfg_data = 3'b101;
    step();
    cfg_we = 1'b0;
    chk("sim_cfg", 5'b01000);
    for (int i = 0; i < 17; i++) step();
    chk("sim_idle_div", 5'b01010);
    ls_access_req = 1'b1;
    hs_access_req = 1'b1;
    step();
    ls_access_req = 1'b0;
    chk("sim_both_stay_ls", 5'b01010);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("sim_dwell_reloaded", 5'b01010);
    end
    step();
    chk("sim_switch_after_dwell", 5'b10010);
    hs_access_req = 1'b0;

    // Timeout: no acknowledge, flags remain LS
    for (int i = 0; i < 255; i++) step();
    chk("timeout_not_yet", 5'b10010);
    step();
    chk("timeout_fault", 5'b01011);
    cfg_we   = 1'b1;
    cfg_data = 3'b100;
    step();
    chk("fault_turbo_write_stays", 5'b01011);
    cfg_data = 3'b000;
    step();
    cfg_we = 1'b0;
    chk("fault_exit", 5'b01010);
    step();
    chk("fault_exit_div_00", 5'b01000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
